// File: rtl/divider_4bit_seq.sv
// divider_4bit_seq: 4-bit unsigned restoring divider, one quotient bit per clock behind START/DONE
module divider_4bit_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       BUSY,
  output logic       DONE,
  output logic       DZ
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t     r_state;
  logic [4:0] r_pr;
  logic [3:0] r_dq;
  logic [3:0] r_dv;
  logic [1:0] r_cnt;
  logic [4:0] w_shift;
  logic [5:0] w_t;
  logic       w_ok;
  logic [4:0] w_pr_next;
  logic [3:0] w_dq_next;
  // trial subtraction as add of inverted divisor plus one; carry out means no borrow
  assign w_shift   = {r_pr[3:0], r_dq[3]};
  assign w_t       = {1'b0, w_shift} + {1'b0, ~{1'b0, r_dv}} + 6'd1;
  assign w_ok      = w_t[5];
  assign w_pr_next = w_ok ? w_t[4:0] : w_shift;
  assign w_dq_next = {r_dq[2:0], w_ok};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_pr    <= '0;
      r_dq    <= '0;
      r_dv    <= '0;
      r_cnt   <= '0;
      Q       <= '0;
      R       <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DZ      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (r_state == IDLE) begin
        if (START && Y != 4'd0) begin
          r_dv    <= Y;
          r_dq    <= X;
          r_pr    <= '0;
          r_cnt   <= '0;
          BUSY    <= 1'b1;
          DZ      <= 1'b0;
          r_state <= CALC;
        end else if (START) begin
          Q    <= 4'hF;
          R    <= X;
          DZ   <= 1'b1;
          DONE <= 1'b1;
        end
      end else begin
        r_pr  <= w_pr_next;
        r_dq  <= w_dq_next;
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          Q       <= w_dq_next;
          R       <= w_pr_next[3:0];
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb_divider_4bit_seq: self-checking bench against an arithmetic model of X/Y and X%Y
module tb_divider_4bit_seq;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [3:0] X = '0;
  logic [3:0] Y = '0;
  logic [3:0] Q, R;
  logic       BUSY, DONE, DZ;
  int checks = 0;
  int failures = 0;

  divider_4bit_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .X(X), .Y(Y),
    .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .DZ(DZ)
  );

  always #5 CLK = ~CLK;

  // Issues one request at a negedge and follows it until its DONE sample.
  // hold keeps START high with junk operands while busy; chain leaves the
  // caller free to start the next request in the DONE cycle.
  task automatic div_op(input logic [3:0] x, input logic [3:0] y, input bit hold, input bit chain);
    logic [3:0] eq, er;
    logic       edz;
    int         lat;
    eq  = (y == 0) ? 4'hF : 4'(x / y);
    er  = (y == 0) ? x : 4'(x % y);
    edz = (y == 0);
    lat = (y == 0) ? 1 : 5;
    START = 1'b1;
    X = x;
    Y = y;
    for (int t = 1; t <= lat; t++) begin
      @(negedge CLK);
      checks++;
      if (DONE !== (t == lat)) begin
        failures++;
        $display("FAIL done_timing x=%0d y=%0d t=%0d got=%b want=%b", x, y, t, DONE, t == lat);
      end
      checks++;
      if (BUSY !== (y != 0 && t < lat)) begin
        failures++;
        $display("FAIL busy x=%0d y=%0d t=%0d got=%b want=%b", x, y, t, BUSY, (y != 0 && t < lat));
      end
      if (t < lat) begin
        START = hold;
        X = 4'($urandom);
        Y = 4'($urandom);
      end
    end
    checks++;
    if (Q !== eq || R !== er || DZ !== edz) begin
      failures++;
      $display("FAIL result x=%0d y=%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
               x, y, Q, R, DZ, eq, er, edz);
    end
    if (!chain) START = 1'b0;
  endtask

  task automatic expect_idle(input string name);
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL %s got done=%b busy=%b want done=0 busy=0", name, DONE, BUSY);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Q, R, BUSY, DONE, DZ} !== 11'd0) begin
      failures++;
      $display("FAIL reset_values got q=%0d r=%0d busy=%b done=%b dz=%b want all 0", Q, R, BUSY, DONE, DZ);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    div_op(4'd13, 4'd3, 0, 0);
    expect_idle("done_width_13_3");
    div_op(4'd15, 4'd1, 0, 0);
    expect_idle("done_width_15_1");
    div_op(4'd5, 4'd7, 0, 0);
    expect_idle("done_width_5_7");
  endtask

  task automatic test_div_zero;
    div_op(4'd9, 4'd0, 0, 0);
    expect_idle("done_width_9_0");
  endtask

  task automatic test_back_to_back;
    div_op(4'd13, 4'd3, 1, 1);
    div_op(4'd2, 4'd2, 0, 0);
    expect_idle("done_width_b2b");
  endtask

  task automatic test_reset_mid;
    START = 1'b1;
    X = 4'd13;
    Y = 4'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({Q, R, BUSY, DONE, DZ} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid got q=%0d r=%0d busy=%b done=%b dz=%b want all 0", Q, R, BUSY, DONE, DZ);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) expect_idle("no_done_after_reset");
    div_op(4'd8, 4'd3, 0, 0);
    expect_idle("done_width_8_3");
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 256; i++) div_op(4'(i >> 4), 4'(i), 0, i != 255);
    expect_idle("done_width_exhaustive");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      bit chain;
      chain = 1'($urandom);
      div_op(4'($urandom), 4'($urandom), 1'($urandom), chain);
      if (!chain) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) expect_idle("random_gap");
      end
    end
    START = 1'b0;
    expect_idle("random_end");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
